pixel_array_responder: RTL

PIXEL_ARRAY_RESPONDER -- requirements
Module: pixel_array_responder

---
 rtl/pixel_array_responder_if.sv | 22 ++
 rtl/pixel_array_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pixel_array_responder_if.sv
// Control and status bundle between the sensor controller and the 2x2 pixel
// array. The two pixel data buses are bidirectional and stay as plain ports.
interface pixel_array_responder_if;
  logic       erase;
  logic       expose;
  logic       convert;
  logic       read1;
  logic       read2;
  logic       conv_done;
  logic       ctrl_err;
  logic [7:0] frame_cnt;

  modport master (
    output erase, expose, convert, read1, read2,
    input  conv_done, ctrl_err, frame_cnt
  );

  modport slave (
    input  erase, expose, convert, read1, read2,
    output conv_done, ctrl_err, frame_cnt
  );
endinterface

// File: rtl/pixel_array_responder.sv
// pixel_array_responder: behavioural 2x2 image-sensor pixel array.
// Each pixel integrates a saturating exposure count, is digitised against a
// shared ramp on pixData1, and is read back a row at a time over the two
// column buses.
//
// Phase decode (priority erase > expose > convert > read1 > read2):
//   phase      | meaning
//   PH_IDLE    | no control high, all pixel state holds
//   PH_ERASE   | clear acc, val and done of every pixel
//   PH_EXPOSE  | acc += gain, saturating at 255
//   PH_CONVERT | latch ramp into val of each pixel whose ramp >= acc
//   PH_READ1   | drive row 1 codes onto pixData1/pixData2
//   PH_READ2   | drive row 2 codes onto pixData1/pixData2
//
// Pixel index order: 0 = row1/col1, 1 = row1/col2, 2 = row2/col1, 3 = row2/col2.
module pixel_array_responder #(
  parameter int G11 = 1,
  parameter int G12 = 2,
  parameter int G21 = 3,
  parameter int G22 = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  pixel_array_responder_if.slave        ctl,
  inout  wire  [7:0]                    pixData1,
  inout  wire  [7:0]                    pixData2
);

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_ERASE   = 3'd1;
  localparam logic [2:0] PH_EXPOSE  = 3'd2;
  localparam logic [2:0] PH_CONVERT = 3'd3;
  localparam logic [2:0] PH_READ1   = 3'd4;
  localparam logic [2:0] PH_READ2   = 3'd5;

  localparam logic [7:0] GAIN [4] = '{8'(G11), 8'(G12), 8'(G21), 8'(G22)};

  logic [2:0] phase;
  logic [2:0] n_active;
  logic       illegal;
  logic [7:0] ramp;
  logic       rd1_en;
  logic       rd2_en;

  logic [7:0] acc [4];
  logic [7:0] val [4];
  logic [3:0] done;
  logic       conv_q;
  logic       rd2_q;
  logic       conv_done_q;
  logic       err_q;
  logic [7:0] frame_q;

  // Widen before adding so a large gain clamps at full scale instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] g);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, g};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  assign n_active = 3'(ctl.erase) + 3'(ctl.expose) + 3'(ctl.convert)
                  + 3'(ctl.read1) + 3'(ctl.read2);
  assign illegal  = (n_active > 3'd1);

  // Priority decode of the level controls into a single active phase.
  always_comb begin
    phase = PH_IDLE;
    if (ctl.erase)        phase = PH_ERASE;
    else if (ctl.expose)  phase = PH_EXPOSE;
    else if (ctl.convert) phase = PH_CONVERT;
    else if (ctl.read1)   phase = PH_READ1;
    else if (ctl.read2)   phase = PH_READ2;
  end

  // Both column buses share the ramp code; column 1 is the one sampled.
  assign ramp = pixData1;

  // Read drivers are gated by reset so the buses release the moment reset falls.
  assign rd1_en   = reset && (phase == PH_READ1);
  assign rd2_en   = reset && (phase == PH_READ2);
  assign pixData1 = rd1_en ? val[0] : (rd2_en ? val[2] : 8'hzz);
  assign pixData2 = rd1_en ? val[1] : (rd2_en ? val[3] : 8'hzz);

  assign ctl.conv_done = conv_done_q;
  assign ctl.ctrl_err  = err_q;
  assign ctl.frame_cnt = frame_q;

  // Pixel state, phase history, status flags and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        val[i] <= '0;
      end
      done        <= '0;
      conv_q      <= 1'b0;
      rd2_q       <= 1'b0;
      conv_done_q <= 1'b0;
      err_q       <= 1'b0;
      frame_q     <= '0;
    end else begin
      conv_q      <= (phase == PH_CONVERT);
      rd2_q       <= (phase == PH_READ2);
      err_q       <= illegal;
      conv_done_q <= &done;

      if (rd2_q && (phase != PH_READ2)) begin
        frame_q <= frame_q + 8'd1;
      end

      // Ramp ended without reaching these pixels: they are full scale.
      if (conv_q && (phase != PH_CONVERT)) begin
        for (int i = 0; i < 4; i++) begin
          if (!done[i]) begin
            val[i]  <= 8'hff;
            done[i] <= 1'b1;
          end
        end
      end

      case (phase)
        PH_ERASE: begin
          for (int i = 0; i < 4; i++) begin
            acc[i] <= '0;
            val[i] <= '0;
          end
          done <= '0;
        end
        PH_EXPOSE: begin
          for (int i = 0; i < 4; i++) begin
            acc[i] <= sat_add(acc[i], GAIN[i]);
          end
        end
        PH_CONVERT: begin
          for (int i = 0; i < 4; i++) begin
            if (!done[i] && (ramp >= acc[i])) begin
              val[i]  <= ramp;
              done[i] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
